// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the SRAM arbiter/sequencer.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  // Sequencer states: one idle/arbitration state plus two cycles per access.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR1  = 3'd1,
    WR2  = 3'd2,
    RD1  = 3'd3,
    RD2  = 3'd4
  } state_e;

endpackage : sram_arb_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the port that wins a tie;
// after every grant it moves to the port that did not win.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant: a lone requester always wins, a tie goes to the favoured port.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Next pointer: favour the loser of this grant (port 0 win -> favour 1).
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[0];
    end
  end

  // Pointer register, reset favours port 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter2

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 256Kx16 SRAM between a display reader (port 0) and
// a rasterizer writer (port 1). Every access is a fixed two-cycle strobe
// sequence; all SRAM pins come straight from flops.
//
// state | meaning
// IDLE  | strobes released, arbitrate and latch the winner's request
// WR1   | WE_N low, DQ driven with write data
// WR2   | WE_N high again, DQ/address held for hold time, ack follows
// RD1   | OE_N low, DQ released to the SRAM
// RD2   | OE_N low, DQ captured into the port's rdata at the closing edge
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [1:0]        p0_be,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [1:0]        p1_be,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N
);

  localparam int LANE_W = DATA_W / 2;

  state_e            state_q;
  logic              port_q;
  logic [1:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_out_q;
  logic              dq_oe_q;
  logic              we_n_q;
  logic              oe_n_q;
  logic              ub_n_q;
  logic              lb_n_q;
  logic              ce_n_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic [1:0]        elig;
  logic [1:0]        grant;
  logic              advance;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_be;
  logic [DATA_W-1:0] rd_mask;

  // A port whose ack is showing this cycle has not yet had a chance to drop
  // its request, so it sits out this arbitration round.
  assign elig    = {p1_req & ~ack_q[1], p0_req & ~ack_q[0]};
  assign advance = (state_q == IDLE);

  rr_arbiter2 u_rr (
    .clk_i     (CLOCK_50),
    .rst_i     (reset),
    .req_i     (advance ? elig : 2'b00),
    .advance_i (advance),
    .grant_o   (grant)
  );

  assign sel_we    = grant[1] ? p1_we    : p0_we;
  assign sel_addr  = grant[1] ? p1_addr  : p0_addr;
  assign sel_wdata = grant[1] ? p1_wdata : p0_wdata;
  assign sel_be    = grant[1] ? p1_be    : p0_be;

  // Disabled byte lanes read back as zero.
  assign rd_mask = {{LANE_W{be_q[1]}}, {LANE_W{be_q[0]}}};

  // Access sequencer with registered SRAM strobes, acks and read data.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      be_q     <= 2'b00;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ce_n_q   <= 1'b1;
      ack_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ce_n_q <= 1'b0;
      ack_q  <= 2'b00;
      case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            port_q <= grant[1];
            addr_q <= sel_addr;
            be_q   <= sel_be;
            ub_n_q <= ~sel_be[1];
            lb_n_q <= ~sel_be[0];
            if (sel_we) begin
              state_q  <= WR1;
              we_n_q   <= 1'b0;
              dq_oe_q  <= 1'b1;
              dq_out_q <= sel_wdata;
            end else begin
              state_q <= RD1;
              oe_n_q  <= 1'b0;
            end
          end
        end
        WR1: begin
          state_q <= WR2;
          we_n_q  <= 1'b1;
        end
        WR2: begin
          state_q        <= IDLE;
          dq_oe_q        <= 1'b0;
          ub_n_q         <= 1'b1;
          lb_n_q         <= 1'b1;
          ack_q[port_q]  <= 1'b1;
        end
        RD1: begin
          state_q <= RD2;
        end
        RD2: begin
          state_q       <= IDLE;
          oe_n_q        <= 1'b1;
          ub_n_q        <= 1'b1;
          lb_n_q        <= 1'b1;
          ack_q[port_q] <= 1'b1;
          if (port_q) begin
            rdata1_q <= SRAM_DQ & rd_mask;
          end else begin
            rdata0_q <= SRAM_DQ & rd_mask;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // DQ is only driven during the write states; the enable is a flop.
  assign SRAM_DQ = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};

  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_CE_N = ce_n_q;
  assign p0_ack    = ack_q[0];
  assign p1_ack    = ack_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a cycle-counted transaction model
// and a behavioural SRAM.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset;
  logic        preq   [2];
  logic        pwe    [2];
  logic [17:0] paddr  [2];
  logic [15:0] pwdata [2];
  logic [1:0]  pbe    [2];
  wire         p0_ack, p1_ack;
  wire  [15:0] p0_rdata, p1_rdata;
  wire  [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  wire         SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N;

  sram_arbiter dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .p0_req    (preq[0]),
    .p0_we     (pwe[0]),
    .p0_addr   (paddr[0]),
    .p0_wdata  (pwdata[0]),
    .p0_be     (pbe[0]),
    .p0_ack    (p0_ack),
    .p0_rdata  (p0_rdata),
    .p1_req    (preq[1]),
    .p1_we     (pwe[1]),
    .p1_addr   (paddr[1]),
    .p1_wdata  (pwdata[1]),
    .p1_be     (pbe[1]),
    .p1_ack    (p1_ack),
    .p1_rdata  (p1_rdata),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_CE_N (SRAM_CE_N)
  );

  // Behavioural SRAM (low 8 address bits, aliasing mirrored in ref_mem).
  logic [15:0] sram [0:255] = '{default: 16'h0000};
  assign SRAM_DQ = (SRAM_OE_N == 1'b0) ? sram[SRAM_ADDR[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (SRAM_WE_N == 1'b0) begin
      if (SRAM_UB_N == 1'b0) sram[SRAM_ADDR[7:0]][15:8] <= SRAM_DQ[15:8];
      if (SRAM_LB_N == 1'b0) sram[SRAM_ADDR[7:0]][7:0]  <= SRAM_DQ[7:0];
    end
  end

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Transaction-level reference model.
  logic [15:0] ref_mem [0:255] = '{default: 16'h0000};
  int          cyc = 0;
  int          ptr_m;
  int          next_free;
  int          ack_cyc [2];
  bit          pend    [2];
  bit          granted [2];
  bit          rd_is   [2];
  logic [15:0] rd_next [2];
  logic [15:0] exp_rd  [2];
  int          g;
  bit          t_we;
  logic [17:0] t_addr;
  logic [15:0] t_data;
  logic [1:0]  t_be;
  logic [17:0] last_addr;
  bit          ce_exp;
  int          mode;

  function automatic logic [15:0] lanes(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic issue(input int p, input bit we, input logic [17:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    preq[p]   = 1'b1;
    pwe[p]    = we;
    paddr[p]  = a;
    pwdata[p] = d;
    pbe[p]    = be;
    pend[p]   = 1'b1;
    granted[p] = 1'b0;
  endtask

  task automatic issue_rand(input int p);
    issue(p, 1'($urandom_range(0, 1)), 18'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
  endtask

  // Decide what the arbiter must do at the coming edge from this cycle's inputs.
  task automatic model_decide();
    bit el [2];
    int w;
    if (reset) begin
      ptr_m = 0; next_free = 0; g = -10;
      for (int p = 0; p < 2; p++) begin
        ack_cyc[p] = -10; granted[p] = 1'b0; exp_rd[p] = 16'h0;
      end
      last_addr = '0;
      ce_exp = 1'b1;
    end else begin
      ce_exp = 1'b0;
      if (cyc >= next_free) begin
        for (int p = 0; p < 2; p++) el[p] = pend[p] && !granted[p] && (ack_cyc[p] != cyc);
        if (el[0] || el[1]) begin
          if (el[0] && el[1]) w = ptr_m;
          else w = el[1] ? 1 : 0;
          ptr_m = 1 - w;
          granted[w] = 1'b1;
          ack_cyc[w] = cyc + 3;
          next_free  = cyc + 3;
          g      = cyc;
          t_we   = pwe[w];
          t_addr = paddr[w];
          t_data = pwdata[w];
          t_be   = pbe[w];
          last_addr = t_addr;
          rd_is[w]  = !t_we;
          if (t_we)
            ref_mem[t_addr[7:0]] = (ref_mem[t_addr[7:0]] & ~lanes(t_be)) | (t_data & lanes(t_be));
          else
            rd_next[w] = ref_mem[t_addr[7:0]] & lanes(t_be);
        end
      end
    end
  endtask

  task automatic step();
    bit act;
    model_decide();
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++)
      if (ack_cyc[p] == cyc && rd_is[p]) exp_rd[p] = rd_next[p];
    check("ack0",   32'(p0_ack),   32'(ack_cyc[0] == cyc));
    check("ack1",   32'(p1_ack),   32'(ack_cyc[1] == cyc));
    check("rdata0", 32'(p0_rdata), 32'(exp_rd[0]));
    check("rdata1", 32'(p1_rdata), 32'(exp_rd[1]));
    check("ce_n",   32'(SRAM_CE_N), 32'(ce_exp));
    check("addr",   32'(SRAM_ADDR), 32'(last_addr));
    check("bus_safe", 32'(!SRAM_WE_N && !SRAM_OE_N), 32'(0));
    act = (g >= 0) && (cyc == g + 1 || cyc == g + 2);
    if (act) begin
      check("we_n", 32'(SRAM_WE_N), 32'(!(t_we && cyc == g + 1)));
      check("oe_n", 32'(SRAM_OE_N), 32'(t_we));
      check("ub_n", 32'(SRAM_UB_N), 32'(!t_be[1]));
      check("lb_n", 32'(SRAM_LB_N), 32'(!t_be[0]));
      if (t_we) check("dq_wdata", 32'(SRAM_DQ), 32'(t_data));
    end else begin
      check("idle_strobes", 32'({SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}), 32'(4'b1111));
    end
    for (int p = 0; p < 2; p++) begin
      if (ack_cyc[p] == cyc) begin
        pend[p] = 1'b0;
        preq[p] = 1'b0;
      end
      if (!pend[p] && mode != 0)
        if (mode == 2 || $urandom_range(0, 3) == 0) issue_rand(p);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pend[0] || pend[1]) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(pend[0] || pend[1]), 32'(0));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    mode  = 0;
    g     = -10;
    ptr_m = 0;
    next_free = 0;
    last_addr = '0;
    for (int p = 0; p < 2; p++) begin
      preq[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = '0; pwdata[p] = '0; pbe[p] = '0;
      pend[p] = 1'b0; granted[p] = 1'b0; rd_is[p] = 1'b0;
      ack_cyc[p] = -10; rd_next[p] = '0; exp_rd[p] = '0;
    end
    step();
    step();
    reset = 1'b0;

    // Single write then read-back.
    issue(1, 1'b1, 18'd13, 16'h0002, 2'b11);
    drain(20);
    issue(0, 1'b0, 18'd13, 16'h0000, 2'b11);
    drain(20);
    check("readback13", 32'(p0_rdata), 32'(16'h0002));

    // Byte lanes, including both lanes disabled.
    issue(1, 1'b1, 18'd40, 16'hABCD, 2'b10);
    drain(20);
    issue(0, 1'b0, 18'd40, 16'h0000, 2'b01);
    drain(20);
    check("bytelane_upper0", 32'(p0_rdata[15:8]), 32'(0));
    issue(1, 1'b1, 18'd41, 16'h1234, 2'b00);
    drain(20);
    issue(0, 1'b0, 18'd41, 16'h0000, 2'b00);
    drain(20);

    // Saturated contention on both ports.
    issue_rand(0);
    issue_rand(1);
    mode = 2;
    repeat (60) step();
    mode = 0;
    drain(20);

    // Reset during WR1 of a port-1 write; the held request completes afterwards.
    issue(1, 1'b1, 18'd77, 16'h5A5A, 2'b11);
    n = 0;
    while (!(g >= 0 && cyc == g + 1 && t_we) && n < 20) begin
      step();
      n++;
    end
    check("reach_wr1", 32'(n < 20), 32'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    drain(20);
    issue(0, 1'b0, 18'd77, 16'h0000, 2'b11);
    drain(20);
    check("reissued_write", 32'(p0_rdata), 32'(16'h5A5A));

    // Random mixed traffic.
    mode = 1;
    repeat (3000) step();
    mode = 0;
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_sram_arbiter
